// File: rtl/keychords_pkg.sv
// Shared types and constants for the lane_judge note engine: FSM states,
// combo width and the combo-to-multiplier mapping.
package keychords_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   localparam int          COMBO_W    = 8;
   localparam int unsigned COMBO_STEP = 8;
   localparam int unsigned MAX_MULT   = 4;

   // Every COMBO_STEP consecutive hits raise the multiplier by one, capped at MAX_MULT.
   function automatic int unsigned combo_mult(input logic [COMBO_W-1:0] combo);
      int unsigned m;
      m = 1 + 32'(combo) / COMBO_STEP;
      if (m > MAX_MULT) m = MAX_MULT;
      return m;
   endfunction

endpackage

// File: rtl/lane_judge_key_edge_sync.sv
// One key lane: 2-FF synchroniser for an async active-low button plus a
// falling-edge detector giving one press pulse per physical press.
module key_edge_sync (
   input  logic clk,
   input  logic resetn,
   input  logic key_n,
   output logic press
);

   // [0],[1] synchroniser, [2] previous synchronised level; all preset to released.
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_q <= 3'b111;
      else         sync_q <= {sync_q[1:0], key_n};
   end

   assign press = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/lane_judge.sv
// Note-lane engine and hit judge: scrolling per-lane bars, song ROM fetch,
// key judging, saturating combo and score. Define LANE_JUDGE_COMBO_EN to let
// the combo scale the score.
module lane_judge
   import keychords_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int BAR_LEN     = 160,
   parameter int HIT_WIN     = 4,
   parameter int SONG_LEN    = 819,
   parameter int SCORE_W     = 16,
   parameter int BASE_POINTS = 1,
   localparam int AW         = $clog2(SONG_LEN+1)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic                       step,
   input  logic [LANES-1:0]           keys_n,
   output logic [AW-1:0]              song_addr,
   input  logic [LANES-1:0]           song_data,
   output logic [LANES*BAR_LEN-1:0]   bars,
   output logic [SCORE_W-1:0]         score,
   output logic [COMBO_W-1:0]         combo,
   output logic [LANES-1:0]           hit,
   output logic [LANES-1:0]           miss,
   output logic                       playing,
   output logic                       done
);

   state_t                           state;
   logic [LANES-1:0][BAR_LEN-1:0]    bar_q, bar_nxt;
   logic [LANES-1:0]                 press, hit_nxt, miss_nxt;
   logic                             live, step_ok, song_left;
   int unsigned                      n_hits, mult, add;
   logic [SCORE_W+32:0]              score_sum;
   logic [COMBO_W:0]                 combo_sum;
   logic [SCORE_W-1:0]               score_nxt;
   logic [COMBO_W-1:0]               combo_nxt;

   // A start in the same cycle discards any step or press.
   assign live      = (state == PLAY) && !start;
   assign step_ok   = live && step;
   assign song_left = song_addr < AW'(SONG_LEN);
   assign bars      = bar_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [BAR_LEN-1:0] win, judged, shifted;
      logic               h, m;

      key_edge_sync u_sync (
         .clk    (clk),
         .resetn (resetn),
         .key_n  (keys_n[i]),
         .press  (press[i])
      );

      // Judge on the pre-shift bar; the cleared note can then no longer fall off.
      always_comb begin
         win = '0;
         for (int b = 0; b < HIT_WIN; b++) win[b] = bar_q[i][b];
         judged = bar_q[i];
         h = 1'b0;
         m = 1'b0;
         if (live && press[i]) begin
            if (|win) begin
               judged = bar_q[i] & ~(win & (~win + BAR_LEN'(1)));
               h = 1'b1;
            end else begin
               m = 1'b1;
            end
         end
         shifted = judged;
         if (step_ok) begin
            shifted = {song_left & song_data[i], judged[BAR_LEN-1:1]};
            if (judged[0]) m = 1'b1;
         end
      end

      assign bar_nxt[i]  = shifted;
      assign hit_nxt[i]  = h;
      assign miss_nxt[i] = m;
   end

   always_comb begin
      n_hits = 0;
      for (int i = 0; i < LANES; i++) n_hits += 32'(hit_nxt[i]);
`ifdef LANE_JUDGE_COMBO_EN
      mult = combo_mult(combo);
`else
      mult = 1;
`endif
      add       = n_hits * BASE_POINTS * mult;
      score_sum = (SCORE_W+33)'(score) + (SCORE_W+33)'(add);
      score_nxt = (|score_sum[SCORE_W+32:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
      combo_sum = (COMBO_W+1)'(combo) + (COMBO_W+1)'(n_hits);
      if (|miss_nxt)              combo_nxt = '0;
      else if (combo_sum[COMBO_W]) combo_nxt = '1;
      else                        combo_nxt = combo_sum[COMBO_W-1:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         bar_q     <= '0;
         song_addr <= '0;
         score     <= '0;
         combo     <= '0;
         hit       <= '0;
         miss      <= '0;
         playing   <= 1'b0;
         done      <= 1'b0;
      end else begin
         hit  <= '0;
         miss <= '0;
         if (start) begin
            state     <= PLAY;
            bar_q     <= '0;
            song_addr <= '0;
            score     <= '0;
            combo     <= '0;
            playing   <= 1'b1;
            done      <= 1'b0;
         end else if (state == PLAY) begin
            bar_q <= bar_nxt;
            hit   <= hit_nxt;
            miss  <= miss_nxt;
            score <= score_nxt;
            combo <= combo_nxt;
            if (step && song_left) song_addr <= song_addr + AW'(1);
            if (!song_left && bar_q == '0) begin
               state   <= DONE;
               playing <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lane_judge.sv
// Directed bench for lane_judge (4 lanes, 16-position bars, 2-position window,
// 20-row song); a second instance with a 4-bit score exercises saturation.
module tb_lane_judge;
   localparam int LANES = 4, BAR_LEN = 16, HIT_WIN = 2, SONG_LEN = 20;
   localparam int AW = $clog2(SONG_LEN+1);

   logic                     clk = 1'b0, resetn = 1'b0, start = 1'b0, step = 1'b0;
   logic [LANES-1:0]         keys_n = '1, song_data = '0;
   logic [AW-1:0]            song_addr, s_addr;
   logic [LANES*BAR_LEN-1:0] bars, s_bars;
   logic [15:0]              score;
   logic [3:0]               s_score;
   logic [7:0]               combo, s_combo;
   logic [LANES-1:0]         hit, miss, s_hit, s_miss;
   logic                     playing, done, s_playing, s_done;
   int                       checks = 0, errors = 0;
   int unsigned              exp9;

   always #5 clk = ~clk;

   lane_judge #(.LANES(LANES), .BAR_LEN(BAR_LEN), .HIT_WIN(HIT_WIN), .SONG_LEN(SONG_LEN),
                .SCORE_W(16), .BASE_POINTS(1)) dut (
      .clk(clk), .resetn(resetn), .start(start), .step(step), .keys_n(keys_n),
      .song_addr(song_addr), .song_data(song_data), .bars(bars), .score(score),
      .combo(combo), .hit(hit), .miss(miss), .playing(playing), .done(done));

   lane_judge #(.LANES(LANES), .BAR_LEN(BAR_LEN), .HIT_WIN(HIT_WIN), .SONG_LEN(SONG_LEN),
                .SCORE_W(4), .BASE_POINTS(7)) dut_sat (
      .clk(clk), .resetn(resetn), .start(start), .step(step), .keys_n(keys_n),
      .song_addr(s_addr), .song_data(song_data), .bars(s_bars), .score(s_score),
      .combo(s_combo), .hit(s_hit), .miss(s_miss), .playing(s_playing), .done(s_done));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_step(input logic [LANES-1:0] row);
      song_data = row;
      step = 1'b1;
      tick();
      step = 1'b0;
      song_data = '0;
   endtask

   // Leaves the caller just after edge E+2, where hit/miss/score are visible.
   task automatic press_key(input logic [LANES-1:0] mask);
      keys_n = ~mask;
      repeat (3) tick();
   endtask

   task automatic release_keys();
      keys_n = '1;
      repeat (4) tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      exp9 = 9;
`ifdef LANE_JUDGE_COMBO_EN
      exp9 = 10;
`endif
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      chk("rst_addr", 64'(song_addr), 0);
      chk("rst_bars", 64'(bars), 0);
      chk("rst_score", 64'(score), 0);
      chk("rst_pulses", 64'({hit, miss, playing, done}), 0);
      do_step(4'hF);
      chk("idle_step_ignored", 64'({song_addr, bars}), 0);

      // Reset and fill
      do_start();
      chk("start_playing", 64'({playing, done}), 64'b10);
      do_step(4'b0001);
      repeat (15) do_step(4'b0000);
      chk("fill_bars", 64'(bars), 64'h0000_0000_0000_0001);
      chk("fill_addr", 64'(song_addr), 16);
      chk("fill_score_combo", 64'({score, combo}), 0);

      // Hit, then a late press
      press_key(4'b0001);
      chk("hit0", 64'({hit, miss}), 64'b0001_0000);
      chk("hit0_score", 64'(score), 1);
      chk("hit0_combo", 64'(combo), 1);
      chk("hit0_bars", 64'(bars), 0);
      chk("sat_first", 64'(s_score), 7);
      tick();
      chk("hit_pulse_one_cycle", 64'(hit), 0);
      release_keys();
      press_key(4'b0001);
      chk("late_miss", 64'({hit, miss}), 64'b0000_0001);
      chk("late_combo", 64'({score, combo}), 64'h0001_00);
      release_keys();

      // Fall-off with a chord one position behind
      do_step(4'b0001);
      do_step(4'b1111);
      repeat (14) do_step(4'b0000);
      chk("pre_fall_bars", 64'(bars), 64'h0002_0002_0002_0003);
      do_step(4'b0000);
      chk("fall_miss", 64'({hit, miss}), 64'b0000_0001);
      chk("fall_bars", 64'(bars), 64'h0001_0001_0001_0001);
      chk("addr_sat", 64'(song_addr), 20);
      press_key(4'b1111);
      chk("chord_hit", 64'({hit, miss}), 64'b1111_0000);
      chk("chord_score", 64'(score), 5);
      chk("chord_combo", 64'(combo), 4);
      chk("sat_chord", 64'(s_score), 15);
      release_keys();
      chk("done_rise", 64'({playing, done}), 64'b01);
      do_step(4'b1111);
      chk("done_step_ignored", 64'({song_addr, bars}), 64'({5'd20, 64'h0}));
      press_key(4'b0001);
      chk("done_press_ignored", 64'({hit, miss, score}), 64'h0005);
      release_keys();

      // Combo multiplier: nine consecutive lane-0 hits
      do_start();
      chk("restart_clear", 64'({song_addr, score, combo, done}), 0);
      repeat (9) do_step(4'b0001);
      repeat (6) do_step(4'b0000);
      chk("combo_bars", 64'(bars), 64'h0000_0000_0000_03FE);
      for (int k = 1; k <= 9; k++) begin
         press_key(4'b0001);
         chk("combo_hit", 64'(hit), 1);
         if (k == 8) chk("combo8", 64'({score, combo}), 64'h0008_08);
         if (k == 9) begin
            chk("combo9_score", 64'(score), 64'(exp9));
            chk("combo9", 64'(combo), 9);
            chk("sat_hold", 64'(s_score), 15);
         end
         release_keys();
         if (k < 9) do_step(4'b0000);
      end
      chk("combo_done", 64'({song_addr, done}), 64'({5'd20, 1'b1}));

      // Start discards a same-cycle step; then step and press in one cycle
      start = 1'b1;
      step = 1'b1;
      song_data = 4'hF;
      tick();
      start = 1'b0;
      step = 1'b0;
      song_data = '0;
      chk("start_discards_step", 64'({song_addr, bars}), 0);
      chk("start_from_done", 64'({playing, done}), 64'b10);
      do_step(4'b0001);
      repeat (15) do_step(4'b0000);
      keys_n = 4'b1110;
      repeat (2) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("simul_hit", 64'({hit, miss}), 64'b0001_0000);
      chk("simul_state", 64'({score, combo}), 64'h0001_01);
      chk("simul_bars_addr", 64'({song_addr, bars}), 64'({5'd17, 64'h0}));
      release_keys();

      // Asynchronous reset mid-song
      do_step(4'b1111);
      chk("midsong_bars", 64'(bars), 64'h8000_8000_8000_8000);
      #3;
      resetn = 1'b0;
      #1;
      chk("async_reset", 64'({song_addr, bars, score, playing}), 0);
      repeat (2) tick();
      resetn = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
